// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Drives the shared open-collector clock/data lines through pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  localparam logic [IW-1:0] I_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] I_MAX  = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
  localparam logic [3:0]    LAST_IDX = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state;
  state_t state_nx;

  logic          c_s1;
  logic          c_s2;
  logic          d_s1;
  logic          d_s2;
  logic [FW-1:0] fcnt;
  logic          c_filt;
  logic          c_filt_q;
  logic          fall;

  logic [9:0]    frame;
  logic [3:0]    idx;
  logic          dbit;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic          tmo;

  // Synchronizers start at the idle (released-high) line level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c_in;
      c_s2 <= c_s1;
      d_s1 <= ps2d_in;
      d_s2 <= d_s1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fcnt     <= '0;
      c_filt   <= 1'b1;
      c_filt_q <= 1'b1;
    end else begin
      c_filt_q <= c_filt;
      if (c_s2 == c_filt) begin
        fcnt <= '0;
      end else if (fcnt == F_LAST) begin
        c_filt <= c_s2;
        fcnt   <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fall = c_filt_q & ~c_filt;
  assign tmo  = (tcnt == T_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (tx_start) state_nx = S_INHIBIT;
      end
      S_INHIBIT: begin
        if (icnt == I_LAST) state_nx = S_REQ;
      end
      S_REQ: begin
        state_nx = tmo ? S_ERR : S_SEND;
      end
      S_SEND: begin
        if (tmo) begin
          state_nx = S_ERR;
        end else if (fall && idx == LAST_IDX) begin
          state_nx = S_ACK;
        end
      end
      S_ACK: begin
        if (tmo) begin
          state_nx = S_ERR;
        end else if (fall) begin
          state_nx = d_s2 ? S_ERR : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (tmo) begin
          state_nx = S_ERR;
        end else if (d_s2 && c_filt) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // frame = {stop, odd parity, data}; dbit is the level the host is driving.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame <= '1;
      idx   <= '0;
      dbit  <= 1'b1;
      icnt  <= '0;
      tcnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          icnt <= '0;
          tcnt <= '0;
          idx  <= '0;
          if (tx_start) begin
            frame <= {1'b1, ~^tx_data, tx_data};
            dbit  <= 1'b0;
          end
        end
        S_INHIBIT: begin
          tcnt <= '0;
          if (icnt != I_MAX) icnt <= icnt + 1'b1;
        end
        S_DONE, S_ERR: begin
          dbit <= 1'b1;
        end
        default: begin
          if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;
          if (state == S_SEND && fall) begin
            dbit <= frame[idx];
            if (idx != LAST_IDX) idx <= idx + 1'b1;
          end
        end
      endcase
    end
  end

  assign ps2c_oe = (state == S_INHIBIT) || (state == S_REQ);
  assign ps2d_oe = ((state == S_REQ) || (state == S_SEND)) && !dbit;
  assign tx_busy = !(state inside {S_IDLE, S_DONE, S_ERR});
  assign tx_done = (state == S_DONE);
  assign tx_err  = (state == S_ERR);

endmodule
